// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch controller: FSM state encoding,
// PC increment and the IF/ID latch payload.
package fetch_pkg;
  localparam int FETCH_XLEN = 64;
  localparam int FETCH_ILEN = 32;
  localparam int unsigned FETCH_INCR = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ILEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] npc;
  } if_id_t;
endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID holding register: load captures a new instruction and sets valid,
// clear drops valid only; payload fields hold until the next load.
import fetch_pkg::*;

module fetch_if_id_reg (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);
  logic   valid_q, valid_d;
  if_id_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one request at a time and
// squashes stale returns on redirect. FETCH_PERF_EN adds perf counters.
import fetch_pkg::*;

module fetch_ctrl #(
  parameter int          XLEN     = FETCH_XLEN,
  parameter int          ILEN     = FETCH_ILEN,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  input  logic            resp_valid,
  input  logic [ILEN-1:0] resp_data,
  output logic            if_id_valid,
  output logic [ILEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_npc,
  input  logic            id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]     perf_fetched,
  output logic [63:0]     perf_squashed
`endif
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_inc;
  logic            ifid_load, ifid_clear;
  if_id_t          ifid_din, ifid_q;

  // Modulo 2^XLEN: the carry out of the top bit is simply dropped.
  assign pc_inc = pc_q + XLEN'(FETCH_INCR);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_valid  = 1'b0;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        req_valid = 1'b1;
        if (redirect_valid) pc_d = redirect_pc;
        if (req_ready) state_d = redirect_valid ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = resp_valid ? S_REQ : S_DRAIN;
        end else if (resp_valid) begin
          ifid_load = 1'b1;
          pc_d      = pc_inc;
          state_d   = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (resp_valid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (redirect_valid) begin
          ifid_clear = 1'b1;
          pc_d       = redirect_pc;
          state_d    = S_REQ;
        end else if (id_ready) begin
          ifid_clear = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= XLEN'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign ifid_din.instr = FETCH_ILEN'(resp_data);
  assign ifid_din.pc    = FETCH_XLEN'(pc_q);
  assign ifid_din.npc   = FETCH_XLEN'(pc_inc);

  fetch_if_id_reg u_if_id (
    .clk   (clk),
    .reset (reset),
    .load  (ifid_load),
    .clear (ifid_clear),
    .d     (ifid_din),
    .valid (if_id_valid),
    .q     (ifid_q)
  );

  assign req_addr    = pc_q;
  assign if_id_instr = ILEN'(ifid_q.instr);
  assign if_id_pc    = XLEN'(ifid_q.pc);
  assign if_id_npc   = XLEN'(ifid_q.npc);

`ifdef FETCH_PERF_EN
  logic        fetched_inc, squashed_inc;
  logic [63:0] fetched_q, fetched_d, squashed_q, squashed_d;

  // A drained response is always dropped; a WAIT response only when redirected.
  always_comb begin
    fetched_inc  = (state_q == S_HOLD) && id_ready && !redirect_valid;
    squashed_inc = ((state_q == S_HOLD) && redirect_valid) ||
                   ((state_q == S_DRAIN) && resp_valid) ||
                   ((state_q == S_WAIT) && resp_valid && redirect_valid);
    fetched_d    = fetched_q + {63'd0, fetched_inc};
    squashed_d   = squashed_q + {63'd0, squashed_inc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else begin
      fetched_q  <= fetched_d;
      squashed_q <= squashed_d;
    end
  end

  assign perf_fetched  = fetched_q;
  assign perf_squashed = squashed_q;
`endif
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Owns the architectural PC and issues one instruction-memory request at a time over a valid/ready handshake. Registers the returned instruction into the IF/ID latch and applies execute-stage redirects, discarding any fetch already in flight. Sits between the PC increment/select datapath, the I-side memory port and decode.

## Interface
Parameters:
- `XLEN`, 64: PC/address width.
- `ILEN`, 32: instruction width.
- `RESET_PC`, 64'h0: PC loaded on reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `redirect_valid` in 1: execute-stage PC redirect (branch/jump taken).
- `redirect_pc` in XLEN: redirect target.
- `req_valid` out 1: memory fetch request.
- `req_addr` out XLEN: fetch address, equal to the current PC.
- `req_ready` in 1: memory accepts the request.
- `resp_valid` in 1: instruction return.
- `resp_data` in ILEN: returned instruction.
- `if_id_valid` out 1: IF/ID latch holds a valid instruction.
- `if_id_instr` out ILEN: latched instruction.
- `if_id_pc` out XLEN: PC of the latched instruction.
- `if_id_npc` out XLEN: `if_id_pc + 4`.
- `id_ready` in 1: decode consumes IF/ID this cycle.

## Operation
States: `S_IDLE`, `S_REQ`, `S_WAIT`, `S_DRAIN`, `S_HOLD`.
- `S_IDLE`: entered only from reset. Moves to `S_REQ` after one cycle.
- `S_REQ`:
  - `req_valid=1`, `req_addr=pc`.
  - On `req_ready`, go to `S_WAIT`.
  - On `redirect_valid`, load `pc<=redirect_pc` and stay in `S_REQ`. This is the only permitted change of `req_addr` while unaccepted.
  - If `redirect_valid` and `req_ready` are both high, the accepted request is stale: load the redirect and go to `S_DRAIN`.
- `S_WAIT`:
  - On `resp_valid`: latch `if_id_instr<=resp_data`, `if_id_pc<=pc`, `if_id_npc<=pc+4`, set `pc<=pc+4`, go to `S_HOLD`.
  - On `redirect_valid` without `resp_valid`: load the redirect and go to `S_DRAIN`.
  - On `redirect_valid` with `resp_valid`: discard the response, load the redirect, go to `S_REQ`.
- `S_DRAIN`: the next `resp_valid` is discarded, then go to `S_REQ`. A further redirect here only updates `pc`.
- `S_HOLD`:
  - `if_id_valid=1`; IF/ID fields stay stable until `id_ready`.
  - On `id_ready`, clear `if_id_valid` and go to `S_REQ`.
  - On `redirect_valid`, clear `if_id_valid` (instruction squashed), load `pc<=redirect_pc`, go to `S_REQ`. Redirect wins over `id_ready` in the same cycle.
- Arithmetic: PC increment is modulo 2^XLEN, so `pc+4` wraps from `FFFF_FFFF_FFFF_FFFC` to 0. `redirect_pc` is used unmodified.
- `resp_valid` outside `S_WAIT`/`S_DRAIN` is ignored.
- At most one outstanding memory request.

## Timing
- Reset values: `req_valid=0`, `req_addr=RESET_PC`, `if_id_valid=0`, `if_id_instr=0`, `if_id_pc=0`, `if_id_npc=0`, state `S_IDLE`.
- Reset asserted mid-operation forces these values immediately (asynchronous). Any in-flight response is not tracked.
- First `req_valid` appears in the 2nd cycle after reset deassertion.
- Request accepted in cycle t with response in cycle t+k gives `if_id_valid=1` from t+k+1. This is registered; there is no combinational path from `resp_data` to `if_id_*`.
- `id_ready` in cycle h gives the next `req_valid` in h+1.
- Redirect in cycle r is seen on `req_addr` in r+1 (except from `S_DRAIN`).

## Configuration
- `FETCH_PERF_EN` defined: adds output `perf_fetched` (64 b, increments per instruction delivered to decode) and output `perf_squashed` (64 b, increments per discarded response or squashed held instruction). Both reset to 0 and wrap.
- `FETCH_PERF_EN` undefined: no counters and no such ports; behaviour is otherwise identical.

## Structure
- `fetch_pkg`: state enum `fetch_state_e`, constant `FETCH_INCR=4`, and the `if_id_t` struct (instr, pc, npc).
- One sub-module, `fetch_if_id_reg`: the IF/ID holding register with load/clear/hold controls. The FSM and PC register stay in `fetch_ctrl`.

## Test plan
- Reset release, `req_ready=1`, 1-cycle memory returning `0x00000013` -> `req_addr=0`, then `if_id_instr=0x13`, `if_id_pc=0`, `if_id_npc=4`; next `req_addr=4`.
- `id_ready=0` for 5 cycles while in `S_HOLD` -> IF/ID stable and `req_valid=0` throughout; `id_ready=1` -> `req_addr=4` the next cycle.
- Redirect to `0x1000` in `S_WAIT`, response 2 cycles later -> that response dropped, `req_addr=0x1000`, `if_id_valid` never set for the old PC.
- Redirect to `0x2000` with `resp_valid` in the same cycle -> response dropped, next `req_addr=0x2000`.
- Redirect and `id_ready` together in `S_HOLD` -> held instruction squashed and not counted in `perf_fetched`; `perf_squashed` +1.
- PC=`FFFF_FFFF_FFFF_FFFC` fetched -> `if_id_npc=0` and next `req_addr=0`. Async reset asserted in `S_WAIT` -> all outputs at reset values within the same cycle.
